conv_frame_sched: RTL and testbench

- Sequences one N×N frame through the `convolutor` datapath.
- Issues pixel reads to the image buffer and drives `convolutor.en`/`data_i` with gap-tolerant timing.
- Tags each valid convolution result with its output row/col and discards border (partial-window) results.
- Sits between the image buffer RAM and the result sink; replaces ad-hoc address/valid counting at the top level.

---
 rtl/conv_frame_sched_pkg.sv | 53 +++++
 rtl/conv_frame_sched_if.sv | 35 +++
 rtl/conv_frame_sched_tag_delay.sv | 61 ++++++
 rtl/conv_frame_sched.sv | 176 +++++++++++++++++
 tb/tb_conv_frame_sched.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_frame_sched_pkg
// Shared types and helpers for the convolution frame scheduler:
//   - state_e      : scheduler FSM states
//   - tag_t        : per-pixel tag {ok, row, col} carried alongside each beat
//   - OUT_DIM / FRAME_PIX : output and frame dimensions for the default build
//   - out_dim(), frame_pix(), make_tag() : helpers usable with any N / K_SIZE
// -----------------------------------------------------------------------------
package conv_frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_N     = 4;
    localparam int DEF_K     = 3;
    localparam int OUT_DIM   = DEF_N - DEF_K + 1;
    localparam int FRAME_PIX = DEF_N * DEF_N;
    localparam int COORD_W   = 16;

    // ok marks a pixel that completes a full KxK window; row/col are already
    // translated into output coordinates (meaningless when ok is low).
    typedef struct packed {
        logic               ok;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic int out_dim(input int n, input int k);
        return n - k + 1;
    endfunction

    function automatic int frame_pix(input int n);
        return n * n;
    endfunction

    // Build the tag for pixel (row, col); km1 is K_SIZE-1.
    function automatic tag_t make_tag(input logic [COORD_W-1:0] row,
                                      input logic [COORD_W-1:0] col,
                                      input logic [COORD_W-1:0] km1);
        tag_t t;
        t.ok  = (row >= km1) && (col >= km1);
        t.row = row - km1;
        t.col = col - km1;
        return t;
    endfunction

endpackage

// File: rtl/conv_frame_sched_if.sv
// -----------------------------------------------------------------------------
// conv_frame_sched_if
// Bundles the scheduler's three data-side buses:
//   image buffer : rd_en_o, rd_addr_o (to RAM), mem_data_i (from RAM)
//   convolutor   : conv_en_o, conv_data_o (to datapath), conv_result_i (back)
//   result sink  : out_valid_o, out_data_o, out_row_o, out_col_o
// The master modport is the scheduler; the slave modport is its environment.
// -----------------------------------------------------------------------------
interface conv_frame_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 14
);
    logic                  rd_en_o;
    logic [ADDR_W-1:0]     rd_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  conv_en_o;
    logic [DATA_WIDTH-1:0] conv_data_o;
    logic [DATA_WIDTH-1:0] conv_result_i;
    logic                  out_valid_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [15:0]           out_row_o;
    logic [15:0]           out_col_o;

    modport master (
        output rd_en_o, rd_addr_o, conv_en_o, conv_data_o,
               out_valid_o, out_data_o, out_row_o, out_col_o,
        input  mem_data_i, conv_result_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, conv_en_o, conv_data_o,
               out_valid_o, out_data_o, out_row_o, out_col_o,
        output mem_data_i, conv_result_i
    );
endinterface

// File: rtl/conv_frame_sched_tag_delay.sv
// -----------------------------------------------------------------------------
// tag_delay
// Fixed-depth shift register for a valid bit plus a WIDTH-bit payload. It
// advances every cycle (no enable), so a beat entering at cycle t leaves at
// cycle t+DEPTH.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears all stages)
//   valid_i    : beat valid entering stage 0
//   data_i     : payload entering stage 0
//   valid_o    : valid bit of the last stage
//   data_o     : payload of the last stage
//   pending_o  : some stage other than the last still holds a valid beat
// -----------------------------------------------------------------------------
module tag_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic             pending_s;

    // Shift valid and payload one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // The last stage is excluded: a beat sitting there is already being
    // presented, so the scheduler may finish on the following cycle.
    always_comb begin
        pending_s = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_s = pending_s | valid_q[i];
        end
    end

    assign valid_o   = valid_q[DEPTH-1];
    assign data_o    = data_q[DEPTH-1];
    assign pending_o = pending_s;

endmodule

// File: rtl/conv_frame_sched.sv
// -----------------------------------------------------------------------------
// conv_frame_sched
// Walks one N x N frame through the convolutor: issues row-major reads to the
// image buffer, forwards each returned pixel to the convolutor with an enable
// one cycle after the read, and tags every result with its output row/col.
// Results whose window is not fully inside the frame are dropped.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset (aborts a frame)
//   start_i     : frame start request, only looked at in IDLE
//   stall_i     : holds off new reads while high (FETCH only)
//   busy_o      : frame in progress (cycle after accept through done_o)
//   done_o      : one-cycle pulse, one cycle after the last result beat
//   bus         : master side of conv_frame_sched_if
//                 (image buffer read port, convolutor port, result port)
//
// Timing: a read decision made in FETCH shows up on rd_en_o/rd_addr_o the
// next cycle; data returns one cycle later together with conv_en_o, and the
// result follows RES_LAT cycles after that.
// -----------------------------------------------------------------------------
module conv_frame_sched
    import conv_frame_sched_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3,
    parameter int ADDR_W     = 14,
    parameter int RES_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stall_i,
    output logic                busy_o,
    output logic                done_o,
    conv_frame_sched_if.master  bus
);

    localparam int                 FRAME_PIX_L = frame_pix(N);
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(FRAME_PIX_L - 1);
    localparam logic [COORD_W-1:0] LAST_COL    = COORD_W'(N - 1);
    localparam logic [COORD_W-1:0] KM1         = COORD_W'(K_SIZE - 1);
    localparam int                 DLY_DEPTH   = 1 + RES_LAT;

    state_e             state_q,   state_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [COORD_W-1:0] row_q,     row_d;
    logic [COORD_W-1:0] col_q,     col_d;
    logic               rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    tag_t               tag_q,     tag_d;
    logic               conv_en_q;

    logic               dly_valid_s;
    logic [TAG_W-1:0]   dly_data_s;
    logic               dly_pending_s;
    tag_t               dly_tag_s;
    logic [DATA_WIDTH-1:0] pix_s;

    // Next-state, read issue and pixel row/col tracking.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        row_d     = row_q;
        col_d     = col_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        tag_d     = tag_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    row_d   = 16'd0;
                    col_d   = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (!stall_i) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    tag_d     = make_tag(row_q, col_q, KM1);
                    addr_d    = addr_q + ADDR_W'(1);
                    if (col_q == LAST_COL) begin
                        col_d = 16'd0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // Finish once nothing is queued behind the beat currently on
                // the result port, so done_o lands one cycle after it.
                if (!rd_en_q && !dly_pending_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            row_q     <= 16'd0;
            col_q     <= 16'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tag_q     <= '0;
            conv_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tag_q     <= tag_d;
            conv_en_q <= rd_en_q;
        end
    end

    // One stage covers the memory read, the rest cover the datapath latency.
    tag_delay #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (rd_en_q),
        .data_i    (tag_q),
        .valid_o   (dly_valid_s),
        .data_o    (dly_data_s),
        .pending_o (dly_pending_s)
    );

    assign dly_tag_s = tag_t'(dly_data_s);
    assign pix_s     = bus.mem_data_i;

    assign bus.rd_en_o     = rd_en_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.conv_en_o   = conv_en_q;
    assign bus.conv_data_o = pix_s;
    assign bus.out_valid_o = dly_valid_s & dly_tag_s.ok;
    assign bus.out_data_o  = bus.conv_result_i;
    assign bus.out_row_o   = dly_tag_s.row;
    assign bus.out_col_o   = dly_tag_s.col;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_frame_sched.sv
// Two schedulers run side by side: instance 0 with N=4, RES_LAT=1 and
// instance 1 with N=K_SIZE=3, RES_LAT=0. Each has an image RAM, a stand-in
// convolutor that returns the pixel it was fed (delayed by RES_LAT), and a
// frame-level reference model checked every cycle on the falling edge.
module tb_conv_frame_sched;

    typedef struct {
        int cyc;
        int row;
        int col;
        int data;
    } beat_t;

    logic        clk;
    logic [1:0]  rst_v;
    logic [1:0]  start_v;
    logic [1:0]  stall_v;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [15:0] img [0:1][0:15];
    int          cyc;
    int          n_checks;
    int          n_errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int NG = (g == 0) ? 4 : 3;
        localparam int RL = (g == 0) ? 1 : 0;
        localparam int KK = 3;
        localparam int NN = NG * NG;

        conv_frame_sched_if #(.DATA_WIDTH(16), .ADDR_W(14)) bus ();

        conv_frame_sched #(
            .N(NG), .DATA_WIDTH(16), .K_SIZE(KK), .ADDR_W(14), .RES_LAT(RL)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_v[g]),
            .start_i (start_v[g]),
            .stall_i (stall_v[g]),
            .busy_o  (busy_v[g]),
            .done_o  (done_v[g]),
            .bus     (bus)
        );

        logic [15:0] mem_q;
        logic [15:0] conv_q;

        // Image RAM with one-cycle read; garbage when not reading.
        always @(posedge clk) begin
            mem_q  <= bus.rd_en_o ? img[g][bus.rd_addr_o[3:0]] : 16'($urandom);
            conv_q <= bus.conv_data_o;
        end

        assign bus.mem_data_i    = mem_q;
        assign bus.conv_result_i = (RL == 0) ? bus.conv_data_o : conv_q;

        // Reference model state
        beat_t q[$];
        bit    active, fetching, e_rd, e_conv, rst_pend, exp_v;
        int    issued, e_addr, last_beat, r, c;
        int    exp_done = -1;

        always @(negedge clk) begin
            if (rst_pend) begin
                check_eq($sformatf("u%0d.rst_outs", g),
                         {busy_v[g], done_v[g], bus.rd_en_o, bus.conv_en_o, bus.out_valid_o,
                          bus.rd_addr_o, bus.out_row_o, bus.out_col_o}, 0);
                active = 0; fetching = 0; e_rd = 0; e_conv = 0; exp_done = -1;
                q.delete();
            end else begin
                check_eq($sformatf("u%0d.rd_en", g), bus.rd_en_o, e_rd);
                if (e_rd) check_eq($sformatf("u%0d.rd_addr", g), bus.rd_addr_o, e_addr);
                check_eq($sformatf("u%0d.conv_en", g), bus.conv_en_o, e_conv);
                check_eq($sformatf("u%0d.busy", g), busy_v[g], active);
                exp_v = (q.size() > 0) && (q[0].cyc == cyc);
                check_eq($sformatf("u%0d.out_valid", g), bus.out_valid_o, exp_v);
                if (exp_v && bus.out_valid_o) begin
                    check_eq($sformatf("u%0d.out_row", g), bus.out_row_o, q[0].row);
                    check_eq($sformatf("u%0d.out_col", g), bus.out_col_o, q[0].col);
                    check_eq($sformatf("u%0d.out_data", g), bus.out_data_o, q[0].data);
                    last_beat = cyc;
                end
                if (exp_v) void'(q.pop_front());
                if (done_v[g] || (active && cyc == exp_done)) begin
                    check_eq($sformatf("u%0d.done_o", g), done_v[g], 1);
                    check_eq($sformatf("u%0d.done_cyc", g), cyc, active ? exp_done : -1);
                    check_eq($sformatf("u%0d.beats_left", g), q.size(), 0);
                    check_eq($sformatf("u%0d.last_beat_gap", g), cyc - last_beat, 1);
                end
            end

            rst_pend = rst_v[g];
            if (!rst_v[g]) begin
                e_conv = e_rd;
                e_rd   = 0;
                if (fetching && !stall_v[g]) begin
                    e_rd   = 1;
                    e_addr = issued;
                    r      = issued / NG;
                    c      = issued % NG;
                    if (r >= KK - 1 && c >= KK - 1)
                        q.push_back('{cyc + 2 + RL, r - (KK - 1), c - (KK - 1), int'(img[g][issued])});
                    issued++;
                    if (issued == NN) begin
                        fetching = 0;
                        exp_done = cyc + 3 + RL;
                    end
                end
                if (!active && start_v[g]) begin
                    active = 1; fetching = 1; issued = 0; exp_done = -1;
                end else if (active && cyc == exp_done) begin
                    active = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse(input int g);
        start_v[g] = 1'b1;
        tick(1);
        start_v[g] = 1'b0;
    endtask

    task automatic fill_rand(input int g);
        for (int i = 0; i < 16; i++) img[g][i] = 16'($urandom);
    endtask

    // Returns in the cycle where done_o is high (or on budget expiry).
    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done_v[g] && n < budget) begin
            tick(1);
            n++;
        end
        if (!done_v[g]) check_eq($sformatf("u%0d.done_timeout", g), 0, 1);
    endtask

    task automatic frame_rand_stall(input int g);
        int n = 0;
        fill_rand(g);
        start_pulse(g);
        while (!done_v[g] && n < 400) begin
            stall_v[g] = ($urandom_range(0, 2) == 0);
            tick(1);
            n++;
        end
        stall_v[g] = 1'b0;
        if (!done_v[g]) check_eq($sformatf("u%0d.done_timeout", g), 0, 1);
        tick(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_v    = 2'b11;
        start_v  = 2'b00;
        stall_v  = 2'b00;
        for (int i = 0; i < 16; i++) begin
            img[0][i] = 16'(i);
            img[1][i] = 16'(i);
        end
        tick(3);
        rst_v = 2'b00;
        tick(2);

        // Nominal ramp frame
        start_pulse(0);
        wait_done(0, 100);
        tick(2);

        // Stall for 3 cycles while address 5 is due
        fill_rand(0);
        start_pulse(0);
        tick(5);
        stall_v[0] = 1'b1;
        tick(3);
        stall_v[0] = 1'b0;
        wait_done(0, 100);
        tick(2);

        // start pulses while busy are ignored
        fill_rand(0);
        start_pulse(0);
        tick(4);
        start_pulse(0);
        tick(6);
        start_pulse(0);
        wait_done(0, 100);
        tick(3);

        // Reset around address 8, then a clean frame
        start_pulse(0);
        tick(8);
        rst_v[0] = 1'b1;
        tick(1);
        rst_v[0] = 1'b0;
        tick(3);
        fill_rand(0);
        start_pulse(0);
        wait_done(0, 100);
        tick(2);

        // Random images with random stalls
        for (int k = 0; k < 3; k++) frame_rand_stall(0);

        // start_i held high: frames back to back
        fill_rand(0);
        start_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(0, 200);
            tick(1);
        end
        tick(1);
        start_v[0] = 1'b0;
        wait_done(0, 200);
        tick(2);

        // N == K_SIZE instance: ramp, random stall, back to back
        start_pulse(1);
        wait_done(1, 100);
        tick(2);
        frame_rand_stall(1);
        frame_rand_stall(1);
        fill_rand(1);
        start_v[1] = 1'b1;
        wait_done(1, 100);
        tick(2);
        start_v[1] = 1'b0;
        wait_done(1, 100);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
